// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: nibble width, default memory geometry
// and the program-loader state encoding.
package cpu_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } load_state_e;

endpackage

// File: rtl/nibble_packer.sv
// Shift register that assembles a memory word from nibbles, MSB nibble first,
// with a nibble counter that wraps to zero when a word completes.
module nibble_packer
    import cpu_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                shift_i,
    input  logic [NIBBLE_W-1:0] data_i,
    output logic [WORD_W-1:0]   next_o,
    output logic                full_o
);

    localparam int NIBBLES = WORD_W / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES + 1);

    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_base_s;

    // A clear starts a fresh word, so it acts as if the count and word were zero.
    always_comb begin
        cnt_base_s = clear_i ? CNT_W'(0) : cnt_q;
        full_o     = (cnt_base_s == CNT_W'(NIBBLES - 1));
        next_o     = ((clear_i ? WORD_W'(0) : word_q) << NIBBLE_W) | WORD_W'(data_i);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= WORD_W'(0);
            cnt_q  <= CNT_W'(0);
        end else if (shift_i) begin
            word_q <= next_o;
            cnt_q  <= full_o ? CNT_W'(0) : cnt_base_s + CNT_W'(1);
        end else if (clear_i) begin
            word_q <= WORD_W'(0);
            cnt_q  <= CNT_W'(0);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: packs a host nibble stream into words, writes them to
// program memory from address 0 and holds the CPU for the whole load.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] in_data,
    input  logic                in_last,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [ADDR_W:0]     word_count
);

    load_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_error_q;
    logic [ADDR_W:0]   word_count_q;

    logic              accepting_s;
    logic              clear_s;
    logic              shift_s;
    logic              word_end_s;
    logic [WORD_W-1:0] next_word_s;

    always_comb begin
        case (state_q)
            S_IDLE, S_COLLECT, S_DRAIN: in_ready = 1'b1;
            default:                    in_ready = 1'b0;
        endcase
    end

    assign accepting_s = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign clear_s     = in_valid && (state_q == S_IDLE);
    assign shift_s     = in_valid && accepting_s;

    nibble_packer #(.WORD_W(WORD_W)) u_packer (
        .clock   (clock),
        .reset   (reset),
        .clear_i (clear_s),
        .shift_i (shift_s),
        .data_i  (in_data),
        .next_o  (next_word_s),
        .full_o  (word_end_s)
    );

    // Load FSM; write strobe, address and data are registered on the transfer
    // of a word's last nibble so they appear during the WRITE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= ADDR_W'(0);
            last_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= ADDR_W'(0);
            mem_wdata_q  <= WORD_W'(0);
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            word_count_q <= (ADDR_W+1)'(0);
        end else begin
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (in_valid) begin
                        if (state_q == S_IDLE) begin
                            word_count_q <= (ADDR_W+1)'(0);
                            load_error_q <= 1'b0;
                            addr_q       <= ADDR_W'(0);
                            cpu_hold_q   <= 1'b1;
                        end
                        if (word_end_s) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= (state_q == S_IDLE) ? ADDR_W'(0) : addr_q;
                            mem_wdata_q <= next_word_s;
                            last_q      <= in_last;
                            state_q     <= S_WRITE;
                        end else if (in_last) begin
                            load_error_q <= 1'b1;
                            load_done_q  <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_WRITE: begin
                    word_count_q <= word_count_q + (ADDR_W+1)'(1);
                    // Saturate at the top so the address can never wrap.
                    if (addr_q != ADDR_W'(DEPTH - 1)) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                    if (last_q) begin
                        load_done_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        load_error_q <= 1'b1;
                        state_q      <= S_DRAIN;
                    end else begin
                        state_q <= S_COLLECT;
                    end
                end
                S_DRAIN: begin
                    if (in_valid && in_last) begin
                        load_done_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    cpu_hold_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    cpu_hold_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign word_count = word_count_q;

endmodule
